// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the counter read-channel arbiter.
// The FSM encoding is fixed at 2 bits so the state register width is stable.
package counter_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10,
      RESP = 2'b11
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY        = 2'b00;
   localparam logic [1:0] RESP_SLVERR      = 2'b10;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/counter_read_arbiter_chk.sv
// Protocol checker for the arbiter's handshake outputs; no design logic here.
module counter_read_arbiter_chk #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12
) (
   input logic               aclk,
   input logic               aresetn,
   input logic [NUM_REQ-1:0] s_arready,
   input logic [NUM_REQ-1:0] s_rvalid,
   input logic               m_arvalid,
   input logic               m_arready,
   input logic [ADDR_W-1:0]  m_araddr,
   input logic               busy
);

   a_arready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
      $onehot0(s_arready));

   a_rvalid_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
      $onehot0(s_rvalid));

   a_addr_hold: assert property (@(posedge aclk) disable iff (!aresetn)
      (m_arvalid && !m_arready) |=> (m_arvalid && $stable(m_araddr)));

   a_busy_cover: assert property (@(posedge aclk) disable iff (!aresetn)
      (m_arvalid || (|s_rvalid)) |-> busy);

endmodule

// File: rtl/counter_read_arbiter_rr_pick.sv
// Combinational round-robin select: the first set request strictly after ptr_i,
// wrapping modulo NUM_REQ, so the last winner has the lowest priority.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               any_o
);

   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   int idx;

   // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
   always_comb begin
      idx         = 0;
      grant_oh_o  = {NUM_REQ{1'b0}};
      grant_idx_o = {IDX_W{1'b0}};
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx         = (int'(ptr_i) + k) % NUM_REQ;
         grant_oh_o  = req_i[idx] ? (ONE << idx) : grant_oh_o;
         grant_idx_o = req_i[idx] ? IDX_W'(idx) : grant_idx_o;
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/counter_read_arbiter.sv
// Round-robin arbiter sharing the counter's AXI4-Lite read channel between
// NUM_REQ requesters, one read in flight, address and response registered.
module counter_read_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 64
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_REQ-1:0]           s_arvalid,
   output logic [NUM_REQ-1:0]           s_arready,
   input  logic [NUM_REQ*ADDR_W-1:0]    s_araddr,
   output logic [NUM_REQ-1:0]           s_rvalid,
   input  logic [NUM_REQ-1:0]           s_rready,
   output logic [DATA_W-1:0]            s_rdata,
   output logic [1:0]                   s_rresp,
   output logic                         m_arvalid,
   input  logic                         m_arready,
   output logic [ADDR_W-1:0]            m_araddr,
   output logic [2:0]                   m_arprot,
   input  logic                         m_rvalid,
   output logic                         m_rready,
   input  logic [DATA_W-1:0]            m_rdata,
   input  logic [1:0]                   m_rresp,
   output logic                         busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   arb_state_e          state_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [IDX_W-1:0]    grant_q;
   logic [ADDR_W-1:0]   araddr_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          rresp_q;
   logic                m_arvalid_q;
   logic                m_rready_q;
   logic [NUM_REQ-1:0]  s_rvalid_q;
   logic                busy_q;

   logic [NUM_REQ-1:0]  pick_oh;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic [ADDR_W-1:0]   pick_addr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i       (s_arvalid),
      .ptr_i       (rr_ptr_q),
      .grant_oh_o  (pick_oh),
      .grant_idx_o (pick_idx),
      .any_o       (pick_any)
   );

   assign pick_addr = s_araddr[pick_idx*ADDR_W +: ADDR_W];

   // The AR accept is the one combinational output; it is gated by reset so
   // nothing handshakes while aresetn is low.
   assign s_arready = (aresetn && (state_q == IDLE)) ? pick_oh : {NUM_REQ{1'b0}};

   // Arbitration FSM; every handshake output is a flop updated with the state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         rr_ptr_q    <= LAST_IDX;
         grant_q     <= {IDX_W{1'b0}};
         araddr_q    <= {ADDR_W{1'b0}};
         rdata_q     <= {DATA_W{1'b0}};
         rresp_q     <= RESP_OKAY;
         m_arvalid_q <= 1'b0;
         m_rready_q  <= 1'b0;
         s_rvalid_q  <= {NUM_REQ{1'b0}};
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  araddr_q    <= pick_addr;
                  grant_q     <= pick_idx;
                  m_arvalid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ADDR;
               end
            end
            ADDR: begin
               if (m_arready) begin
                  m_arvalid_q <= 1'b0;
                  m_rready_q  <= 1'b1;
                  state_q     <= DATA;
               end
            end
            DATA: begin
               if (m_rvalid) begin
                  rdata_q    <= m_rdata;
                  rresp_q    <= m_rresp;
                  m_rready_q <= 1'b0;
                  s_rvalid_q <= idx_onehot(grant_q);
                  state_q    <= RESP;
               end
            end
            RESP: begin
               // The winner becomes lowest priority for the next arbitration.
               if (s_rready[grant_q]) begin
                  s_rvalid_q <= {NUM_REQ{1'b0}};
                  busy_q     <= 1'b0;
                  rr_ptr_q   <= grant_q;
                  state_q    <= IDLE;
               end
            end
            default: begin
               m_arvalid_q <= 1'b0;
               m_rready_q  <= 1'b0;
               s_rvalid_q  <= {NUM_REQ{1'b0}};
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign m_arvalid = m_arvalid_q;
   assign m_araddr  = araddr_q;
   assign m_arprot  = AXI_PROT_DEFAULT;
   assign m_rready  = m_rready_q;
   assign s_rvalid  = s_rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign busy      = busy_q;
   assign grant_id  = grant_q;

   counter_read_arbiter_chk #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W)
   ) u_chk (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_arready (s_arready),
      .s_rvalid  (s_rvalid),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_araddr  (m_araddr),
      .busy      (busy)
   );

endmodule

// File: doc/counter_read_arbiter.md
Name: counter_read_arbiter

Overview:
- Round-robin arbiter that shares the AXI4-Lite read channel (AR/R) of the 64-bit free-running counter block between NUM_REQ independent AXI4-Lite read requesters.
- Exactly one read in flight at a time; the address and response are registered in both directions.
- Sits in the aclk domain between the requesters (CPU, trace unit, DMA timestamper) and the counter's read slave port. The counter's write channel is not routed through this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 12, AXI-Lite address width.
- DATA_W, 64, read data width.

Ports:
- aclk  in  1  bus clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_arvalid  in  NUM_REQ  per-requester AR valid.
- s_arready  out  NUM_REQ  per-requester AR ready; at most one bit high.
- s_araddr  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- s_rvalid  out  NUM_REQ  per-requester R valid; at most one bit high.
- s_rready  in  NUM_REQ  per-requester R ready.
- s_rdata  out  DATA_W  shared read data; meaningful only with the matching s_rvalid bit.
- s_rresp  out  2  shared read response.
- m_arvalid  out  1  AR valid to the counter.
- m_arready  in  1  AR ready from the counter.
- m_araddr  out  ADDR_W  registered address to the counter.
- m_arprot  out  3  tied to 3'b000.
- m_rvalid  in  1  R valid from the counter.
- m_rready  out  1  R ready to the counter.
- m_rdata  in  DATA_W  counter read data.
- m_rresp  in  2  counter read response.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0.
  - All valid/ready outputs 0; m_araddr, s_rdata and s_rresp are 0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any s_arvalid is high, pick winner g: the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - s_arready[g]=1 combinationally in the same cycle; this is the only Mealy output.
  - On that edge: m_araddr<=s_araddr[g], grant_id<=g, state<=ADDR.
  - If no s_arvalid is high, stay in IDLE.
- ADDR:
  - m_arvalid=1 with m_araddr held stable.
  - On m_arvalid&m_arready, go to DATA.
- DATA:
  - m_rready=1.
  - On m_rvalid, capture m_rdata into s_rdata and m_rresp into s_rresp, then go to RESP.
- RESP:
  - s_rvalid[grant_id]=1; s_rdata and s_rresp held stable.
  - On s_rready[grant_id]: rr_ptr<=grant_id, state<=IDLE.
- Best-case latency, with the counter responding m_arready and m_rvalid in their first cycle:
  - AR accept at cycle 0; m_arvalid in cycle 1; R captured at the end of cycle 2; s_rvalid in cycle 3.
  - A new grant is possible in cycle 4 (the cycle after the R handshake).
- Fairness: the last winner has lowest priority. With all requesters continuously requesting, grant order is 0,1,2,...,NUM_REQ-1,0,...
- Simultaneous events:
  - New s_arvalid bits raised during ADDR/DATA/RESP are ignored until IDLE; s_arready stays 0 for them.
  - A requester raising s_arvalid in the same cycle the FSM returns to IDLE is arbitrated in the next cycle.
- s_rresp is passed through unmodified (OKAY, SLVERR, etc.); the arbiter generates no errors itself.
- A requester holding s_rready low stalls the arbiter indefinitely in RESP. This is intended; no timeout.
- Requesters must obey AXI rules: s_arvalid held until s_arready, and s_araddr stable while valid.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight read is abandoned. The counter shares aresetn, so no orphan R beat survives.

Decomposition:
- Package counter_arb_pkg:
  - FSM state enum (IDLE/ADDR/DATA/RESP, 2 bits).
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - AXI_PROT_DEFAULT=3'b000.
- Sub-module rr_pick: combinational round-robin select.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any-valid flag.
  - The top owns rr_ptr and the FSM.

Test Plan:
- Single read: requester 1 issues araddr=12'h000; counter returns 64'h0000_0000_0000_1234 OKAY -> s_rvalid[1] in cycle 3 with that data; grant_id=1; busy falls after s_rready.
- Contention: s_arvalid=4'b1111 held -> grants in order 0,1,2,3,0; no requester is granted twice before the others are served.
- Fairness: requester 0 requests continuously while requester 2 raises one request -> requester 2 is granted immediately after the in-flight requester-0 read; requester 0 never wins twice in a row while 2 is waiting.
- Back-pressure: m_arready delayed 3 cycles, m_rvalid delayed 5 cycles, s_rready delayed 4 cycles -> m_araddr, s_rdata and s_rresp stable throughout; only one s_rvalid bit is high.
- Error pass-through: counter returns m_rresp=2'b10 -> s_rresp=2'b10 delivered to the granted requester only.
- Reset in DATA: drop aresetn for 2 cycles -> all outputs 0 and busy=0 asynchronously; the first post-reset request from requester 0 wins (rr_ptr=NUM_REQ-1).
